// File: rtl/radar_pkg.sv
// Shared types and helpers for the radar timing blocks (generator and statistics).
package radar_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        RUN      = 2'd1,
        STOPPING = 2'd2
    } state_t;

    localparam int unsigned DEF_DATA_WIDTH = 32;
    localparam int unsigned CFG_W          = 64;
    localparam int unsigned MIN_PERIOD_US  = 2;

    // Config is usable when both periods leave room for a low tick and a revolution has ACPs.
    function automatic logic cfg_valid(input logic [CFG_W-1:0] trig_period_us,
                                       input logic [CFG_W-1:0] acp_period_us,
                                       input logic [CFG_W-1:0] acp_per_arp);
        return (trig_period_us >= CFG_W'(MIN_PERIOD_US)) &&
               (acp_period_us  >= CFG_W'(MIN_PERIOD_US)) &&
               (acp_per_arp    != '0);
    endfunction

endpackage

// File: rtl/us_tick_sync.sv
// Brings the asynchronous microsecond clock into SYS_CLK and emits a one-cycle tick per rising edge.
module us_tick_sync (
    input  logic SYS_CLK,
    input  logic RST_N,
    input  logic US_CLK,
    output logic us_tick
);

    logic sync0;
    logic sync1;
    logic sync1_d;

    // Two-flop synchronizer, edge history, registered tick (3 SYS_CLK after the US_CLK edge).
    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            sync0   <= 1'b0;
            sync1   <= 1'b0;
            sync1_d <= 1'b0;
            us_tick <= 1'b0;
        end else begin
            sync0   <= US_CLK;
            sync1   <= sync0;
            sync1_d <= sync1;
            us_tick <= sync1 & ~sync1_d;
        end
    end

endmodule

// File: rtl/radar_signal_generator.sv
// Generates ARP/ACP/TRIG pulse trains from microsecond-programmed periods, counted in us_ticks.
module radar_signal_generator
    import radar_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned PULSE_US   = 1
) (
    input  logic                  SYS_CLK,
    input  logic                  RST_N,
    input  logic                  US_CLK,
    input  logic                  EN,
    input  logic [DATA_WIDTH-1:0] TRIG_PERIOD_US,
    input  logic [DATA_WIDTH-1:0] ACP_PERIOD_US,
    input  logic [DATA_WIDTH-1:0] ACP_PER_ARP,
    output logic                  ARP,
    output logic                  ACP,
    output logic                  TRIG,
    output logic [DATA_WIDTH-1:0] ACP_IDX,
    output logic [DATA_WIDTH-1:0] ARP_CNT,
    output logic                  BUSY,
    output logic                  CFG_ERR
);

    localparam int unsigned         PW_W     = 8;
    localparam logic [DATA_WIDTH-1:0] PULSE_DW = DATA_WIDTH'(PULSE_US);
    localparam logic [DATA_WIDTH-1:0] ONE      = DATA_WIDTH'(1);

    logic us_tick;

    us_tick_sync u_tick (
        .SYS_CLK (SYS_CLK),
        .RST_N   (RST_N),
        .US_CLK  (US_CLK),
        .us_tick (us_tick)
    );

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] sh_trig_q, sh_trig_d;
    logic [DATA_WIDTH-1:0] sh_acp_q, sh_acp_d;
    logic [DATA_WIDTH-1:0] sh_arp_q, sh_arp_d;
    logic [DATA_WIDTH-1:0] us_cnt_q, us_cnt_d;
    logic [DATA_WIDTH-1:0] trig_cnt_q, trig_cnt_d;
    logic [DATA_WIDTH-1:0] acp_idx_q, acp_idx_d;
    logic [DATA_WIDTH-1:0] arp_cnt_q, arp_cnt_d;
    logic                  first_arp_q, first_arp_d;
    logic                  arp_q, arp_d, acp_q, acp_d, trig_q, trig_d;
    logic [PW_W-1:0]       arp_w_q, arp_w_d, acp_w_q, acp_w_d, trig_w_q, trig_w_d;
    logic                  cfg_err_q, cfg_err_d;
    logic                  busy_q, busy_d;

    logic                  cfg_ok;
    logic                  wrap_us;
    logic                  wrap_arp;
    logic [15:0]           arp_prod;
    logic [DATA_WIDTH-1:0] arp_period;

    // Remaining-ticks reload value: width is min(PULSE_US, period-1), stored minus one.
    function automatic logic [PW_W-1:0] pw_m1(input logic [DATA_WIDTH-1:0] period);
        if ((period - ONE) < PULSE_DW)
            return PW_W'(period - DATA_WIDTH'(2));
        else
            return PW_W'(PULSE_US - 32'd1);
    endfunction

    assign cfg_ok   = cfg_valid(CFG_W'(TRIG_PERIOD_US), CFG_W'(ACP_PERIOD_US), CFG_W'(ACP_PER_ARP));
    assign wrap_us  = (us_cnt_q == sh_acp_q - ONE);
    assign wrap_arp = wrap_us && (acp_idx_q == sh_arp_q - ONE);

    // Revolution length only matters below 256 (PULSE_US bound), so saturate large products.
    assign arp_prod   = 16'(sh_acp_q[7:0]) * 16'(sh_arp_q[7:0]);
    assign arp_period = ((|sh_acp_q[DATA_WIDTH-1:8]) || (|sh_arp_q[DATA_WIDTH-1:8]))
                        ? '1 : DATA_WIDTH'(arp_prod);

    always_ff @(posedge SYS_CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= IDLE;
            sh_trig_q   <= '0;
            sh_acp_q    <= '0;
            sh_arp_q    <= '0;
            us_cnt_q    <= '0;
            trig_cnt_q  <= '0;
            acp_idx_q   <= '0;
            arp_cnt_q   <= '0;
            first_arp_q <= 1'b0;
            arp_q       <= 1'b0;
            acp_q       <= 1'b0;
            trig_q      <= 1'b0;
            arp_w_q     <= '0;
            acp_w_q     <= '0;
            trig_w_q    <= '0;
            cfg_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sh_trig_q   <= sh_trig_d;
            sh_acp_q    <= sh_acp_d;
            sh_arp_q    <= sh_arp_d;
            us_cnt_q    <= us_cnt_d;
            trig_cnt_q  <= trig_cnt_d;
            acp_idx_q   <= acp_idx_d;
            arp_cnt_q   <= arp_cnt_d;
            first_arp_q <= first_arp_d;
            arp_q       <= arp_d;
            acp_q       <= acp_d;
            trig_q      <= trig_d;
            arp_w_q     <= arp_w_d;
            acp_w_q     <= acp_w_d;
            trig_w_q    <= trig_w_d;
            cfg_err_q   <= cfg_err_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        sh_trig_d   = sh_trig_q;
        sh_acp_d    = sh_acp_q;
        sh_arp_d    = sh_arp_q;
        us_cnt_d    = us_cnt_q;
        trig_cnt_d  = trig_cnt_q;
        acp_idx_d   = acp_idx_q;
        arp_cnt_d   = arp_cnt_q;
        first_arp_d = first_arp_q;
        arp_d       = arp_q;
        acp_d       = acp_q;
        trig_d      = trig_q;
        arp_w_d     = arp_w_q;
        acp_w_d     = acp_w_q;
        trig_w_d    = trig_w_q;
        cfg_err_d   = cfg_err_q;

        case (state_q)
            IDLE: begin
                if (EN) begin
                    if (cfg_ok) begin
                        state_d     = RUN;
                        sh_trig_d   = TRIG_PERIOD_US;
                        sh_acp_d    = ACP_PERIOD_US;
                        sh_arp_d    = ACP_PER_ARP;
                        us_cnt_d    = '0;
                        trig_cnt_d  = '0;
                        acp_idx_d   = '0;
                        arp_cnt_d   = '0;
                        first_arp_d = 1'b1;
                        cfg_err_d   = 1'b0;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end

            RUN, STOPPING: begin
                if (state_q == RUN && !EN)
                    state_d = STOPPING;
                if (state_q == STOPPING && EN)
                    state_d = RUN;

                if (us_tick) begin
                    if (state_q == STOPPING && !EN && wrap_arp) begin
                        // Stop at the revolution end: suppress the next ARP and drop anything still high.
                        state_d    = IDLE;
                        us_cnt_d   = '0;
                        trig_cnt_d = '0;
                        acp_idx_d  = '0;
                        arp_d      = 1'b0;
                        acp_d      = 1'b0;
                        trig_d     = 1'b0;
                        arp_w_d    = '0;
                        acp_w_d    = '0;
                        trig_w_d   = '0;
                    end else begin
                        if (arp_q) begin
                            if (arp_w_q == '0) arp_d = 1'b0;
                            else arp_w_d = arp_w_q - PW_W'(1);
                        end
                        if (acp_q) begin
                            if (acp_w_q == '0) acp_d = 1'b0;
                            else acp_w_d = acp_w_q - PW_W'(1);
                        end
                        if (trig_q) begin
                            if (trig_w_q == '0) trig_d = 1'b0;
                            else trig_w_d = trig_w_q - PW_W'(1);
                        end

                        if (trig_cnt_q == '0) begin
                            trig_d   = 1'b1;
                            trig_w_d = pw_m1(sh_trig_q);
                        end
                        if (us_cnt_q == '0) begin
                            acp_d   = 1'b1;
                            acp_w_d = pw_m1(sh_acp_q);
                            if (acp_idx_q == '0) begin
                                arp_d   = 1'b1;
                                arp_w_d = pw_m1(arp_period);
                                if (first_arp_q) first_arp_d = 1'b0;
                                else arp_cnt_d = arp_cnt_q + ONE;
                            end
                        end

                        // TRIG phase restarts at every ACP so the last interval may be truncated.
                        if (wrap_us) begin
                            us_cnt_d   = '0;
                            trig_cnt_d = '0;
                            acp_idx_d  = wrap_arp ? '0 : acp_idx_q + ONE;
                        end else begin
                            us_cnt_d   = us_cnt_q + ONE;
                            trig_cnt_d = (trig_cnt_q == sh_trig_q - ONE) ? '0 : trig_cnt_q + ONE;
                        end

                        // New config applies from the next revolution; a bad one is flagged and ignored.
                        if (wrap_arp) begin
                            if (cfg_ok) begin
                                sh_trig_d = TRIG_PERIOD_US;
                                sh_acp_d  = ACP_PERIOD_US;
                                sh_arp_d  = ACP_PER_ARP;
                            end else begin
                                cfg_err_d = 1'b1;
                            end
                        end
                    end
                end
            end

            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    assign ARP     = arp_q;
    assign ACP     = acp_q;
    assign TRIG    = trig_q;
    assign ACP_IDX = acp_idx_q;
    assign ARP_CNT = arp_cnt_q;
    assign BUSY    = busy_q;
    assign CFG_ERR = cfg_err_q;

endmodule
